// File: rtl/ser_pkg.sv
// Shared types and width helpers for the serial transmit scheduler.
package ser_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } ser_state_t;

  function automatic int src_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ser_tx_sched_if.sv
// Requester handshake plus serial output bundle for ser_tx_sched.
interface ser_tx_sched_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
);
  import ser_pkg::*;
  localparam int SRC_W = src_w(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   ser_q;
  logic                   ser_valid;
  logic                   ser_first;
  logic                   ser_last;
  logic [SRC_W-1:0]       ser_src;
  logic                   busy;

  modport slave (
    input  req_valid, req_data,
    output req_ready, ser_q, ser_valid, ser_first, ser_last, ser_src, busy
  );

  modport master (
    output req_valid, req_data,
    input  req_ready, ser_q, ser_valid, ser_first, ser_last, ser_src, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or
// after ptr, wrapping around; all-zero grant when nothing is requested.
module rr_arbiter
  import ser_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]           req,
  input  logic [src_w(N)-1:0]    ptr,
  output logic [N-1:0]           gnt
);

  int idx;

  // Walk from the farthest candidate back to ptr so the closest one wins.
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ser_tx_sched.sv
// Round-robin scheduler feeding one LSB-first parallel-to-serial shifter from
// N_REQ valid/ready requesters, with frame strobes, source ID and GAP idle cycles.
module ser_tx_sched
  import ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int GAP   = 1
) (
  input logic           clk,
  input logic           rst,
  ser_tx_sched_if.slave bus
);

  localparam int SRC_W = src_w(N_REQ);
  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WIDTH - 2);
  localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  ser_state_t        state, state_nx;
  logic [WIDTH-2:0]  shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [3:0]        gap_cnt;
  logic [SRC_W-1:0]  rr_ptr, gnt_idx, src_r;
  logic [N_REQ-1:0]  gnt;
  logic [WIDTH-1:0]  gnt_word;
  logic              take;
  logic              q_nx, first_nx, last_nx, valid_nx, busy_nx;
  logic              q_r, first_r, last_r, valid_r, busy_r;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    gnt_idx  = '0;
    gnt_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = SRC_W'(i);
        gnt_word = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.req_ready = (state == S_IDLE) ? gnt : '0;
  assign take          = (state == S_IDLE) && (|gnt);

  // Output strobes are computed one cycle ahead so every ser_* pin is a flop.
  always_comb begin
    state_nx = state;
    q_nx     = 1'b0;
    first_nx = 1'b0;
    last_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (take) begin
          state_nx = S_SHIFT;
          q_nx     = gnt_word[0];
          first_nx = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          state_nx = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          q_nx    = shreg[0];
          last_nx = (bit_cnt == PRE_LAST);
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    valid_nx = (state_nx == S_SHIFT);
    busy_nx  = (state_nx != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      rr_ptr  <= '0;
      src_r   <= '0;
      q_r     <= 1'b0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state   <= state_nx;
      q_r     <= q_nx;
      first_r <= first_nx;
      last_r  <= last_nx;
      valid_r <= valid_nx;
      busy_r  <= busy_nx;
      if (take) begin
        shreg   <= gnt_word[WIDTH-1:1];
        bit_cnt <= '0;
        src_r   <= gnt_idx;
        rr_ptr  <= (gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (state == S_SHIFT) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : 4'd0;
    end
  end

  assign bus.ser_q     = q_r;
  assign bus.ser_first = first_r;
  assign bus.ser_last  = last_r;
  assign bus.ser_valid = valid_r;
  assign bus.ser_src   = src_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_ser_tx_sched.sv
// Scoreboard bench for ser_tx_sched: directed scenarios plus randomized traffic
// checked against a cycle-count reference model of grants and serial frames.
module tb_ser_tx_sched;
  import ser_pkg::*;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int G  = 1;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  ser_tx_sched_if #(.WIDTH(W), .N_REQ(N)) bus ();
  ser_tx_sched_if #(.WIDTH(W), .N_REQ(N)) bus0 ();

  ser_tx_sched #(.WIDTH(W), .N_REQ(N), .GAP(G)) dut  (.clk(clk), .rst(rst), .bus(bus));
  ser_tx_sched #(.WIDTH(W), .N_REQ(N), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             src;
    logic [W-1:0]   data;
    int             t;
  } exp_t;

  exp_t       sb[$];
  logic [N-1:0] hs = '0;
  logic [N-1:0] keep = '0;
  bit         rand_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a word accepted at cycle T owns the line until T+W+G,
  // bits appear at T+1+k, and grants go to the first valid at/after the pointer.
  task automatic monitor();
    int ptr_m = 0, next_free = 0, t_last = 0, g, k, idx;
    logic [N-1:0] exp_rdy;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        ptr_m = 0; next_free = 0; t_last = 0; hs = '0;
        continue;
      end
      exp_rdy = '0;
      g = -1;
      if (cyc >= next_free) begin
        for (int j = N - 1; j >= 0; j--) begin
          idx = (ptr_m + j) % N;
          if (bus.req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      hs = bus.req_valid & bus.req_ready;
      if (g >= 0) begin
        e.src = g; e.data = bus.req_data[g*W +: W]; e.t = cyc;
        sb.push_back(e);
        ptr_m = (g + 1) % N; t_last = cyc; next_free = cyc + W + G + 1;
      end
      chk("busy", 64'(bus.busy), 64'(cyc > t_last && cyc < next_free));
      if (bus.ser_valid) begin
        if (sb.size() == 0) chk("ser_valid_unexpected", 64'd1, 64'd0);
        else begin
          e = sb[0];
          k = cyc - e.t - 1;
          chk("bit_index_in_range", 64'(k >= 0 && k < W), 64'd1);
          if (k >= 0 && k < W) begin
            chk("ser_q", 64'(bus.ser_q), 64'(e.data[k]));
            chk("ser_src", 64'(bus.ser_src), 64'(e.src));
            chk("ser_first", 64'(bus.ser_first), 64'(k == 0));
            chk("ser_last", 64'(bus.ser_last), 64'(k == W - 1));
          end
          if (k >= W - 1 || k < 0) void'(sb.pop_front());
        end
      end else begin
        chk("idle_outputs", 64'({bus.ser_q, bus.ser_first, bus.ser_last}), 64'd0);
        if (sb.size() > 0 && cyc > sb[0].t) begin
          chk("word_missing", 64'd1, 64'd0);
          void'(sb.pop_front());
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          bus.req_valid[i] = keep[i];
          bus.req_data[i*W +: W] = W'($urandom);
        end else if (rand_mode) begin
          if (!bus.req_valid[i] && $urandom_range(0, 7) == 0) begin
            bus.req_valid[i] = 1'b1;
            bus.req_data[i*W +: W] = W'($urandom);
          end else if (bus.req_valid[i] && $urandom_range(0, 15) == 0) begin
            bus.req_valid[i] = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            bus.req_data[i*W +: W] = W'($urandom);
          end
        end
      end
    end
  endtask

  task automatic wait_hs(input int i, input string name);
    int b = 0;
    do begin
      step(1);
      b++;
    end while (!hs[i] && b < 60);
    chk(name, 64'(hs[i]), 64'd1);
  endtask

  task automatic gap0_test();
    int           hs_t[$], last_t[$], first_t[$], src_l[$];
    logic [W-1:0] words[$];
    logic [W-1:0] cur = '0;
    int           pos = 0;
    logic [N-1:0] h0;
    bus0.req_data[1*W +: W] = 8'hFF;
    bus0.req_data[2*W +: W] = 8'h00;
    bus0.req_valid = 4'b0110;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      h0 = bus0.req_valid & bus0.req_ready;
      if (|h0) hs_t.push_back(cyc);
      if (bus0.ser_valid) begin
        if (bus0.ser_first) begin pos = 0; first_t.push_back(cyc); src_l.push_back(int'(bus0.ser_src)); end
        if (pos < W) cur[pos] = bus0.ser_q;
        pos++;
        if (bus0.ser_last) begin words.push_back(cur); last_t.push_back(cyc); end
      end
      @(posedge clk); #1;
      bus0.req_valid = bus0.req_valid & ~h0;
    end
    chk("g0_handshakes", 64'(hs_t.size()), 64'd2);
    chk("g0_words", 64'(words.size()), 64'd2);
    if (hs_t.size() == 2 && words.size() == 2 && first_t.size() == 2) begin
      chk("g0_back_to_back", 64'(hs_t[1]), 64'(last_t[0] + 1));
      chk("g0_valid_low_cycles", 64'(first_t[1] - last_t[0] - 1), 64'd1);
      chk("g0_word0", 64'(words[0]), 64'hFF);
      chk("g0_word1", 64'(words[1]), 64'h00);
      chk("g0_src0", 64'(src_l[0]), 64'd1);
      chk("g0_src1", 64'(src_l[1]), 64'd2);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid  = '0; bus.req_data  = '0;
    bus0.req_valid = '0; bus0.req_data = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ser", 64'({bus.ser_q, bus.ser_valid, bus.ser_first, bus.ser_last}), 64'd0);
    chk("rst_src", 64'(bus.ser_src), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;

    // Single word from requester 2
    bus.req_data[2*W +: W] = 8'hA5;
    bus.req_valid[2] = 1'b1;
    wait_hs(2, "single_hs");
    step(14);

    // All requesters continuously valid
    keep = '1;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = W'($urandom);
    bus.req_valid = '1;
    step(45);
    keep = '0;
    step(45);

    // Pointer to 2 via requester 1, then only 1 and 3 compete
    bus.req_valid[1] = 1'b1;
    wait_hs(1, "skip_setup_hs");
    step(12);
    keep = 4'b1010;
    bus.req_valid = 4'b1010;
    step(35);
    keep = '0;
    step(25);

    // Valid raised while shifting, withdrawn during GAP
    bus.req_valid[0] = 1'b1;
    wait_hs(0, "withdraw_setup_hs");
    step(3);
    bus.req_valid[1] = 1'b1;
    step(5);
    bus.req_valid[1] = 1'b0;
    step(10);
    chk("withdraw_idle", 64'({bus.busy, bus.ser_valid}), 64'd0);

    // Reset during bit 4 of 8'h3C
    bus.req_data[3*W +: W] = 8'h3C;
    bus.req_valid[3] = 1'b1;
    wait_hs(3, "rst_word_hs");
    step(4);
    chk("bit4_before_rst", 64'({bus.ser_valid, bus.ser_q}), 64'b11);
    rst = 1'b1;
    #1;
    chk("rst_mid_ser", 64'({bus.ser_q, bus.ser_valid, bus.ser_first, bus.ser_last}), 64'd0);
    chk("rst_mid_busy_src", 64'({bus.busy, bus.ser_src}), 64'd0);
    step(2);
    rst = 1'b0;
    bus.req_valid = 4'b0101;
    step(1);
    chk("post_rst_grant", 64'(hs), 64'b0001);
    step(25);

    gap0_test();

    // Randomized traffic
    rand_mode = 1'b1;
    for (int c = 0; c < 10; c++) begin
      keep = N'($urandom);
      step(200);
    end
    rand_mode = 1'b0;
    keep = '0;
    bus.req_valid = '0;
    step(30);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
